// File: rtl/opnd_resolve_seq.sv
// ---------------------------------------------------------------------------
// opnd_resolve_seq
//
// Sequential operand resolver sitting between decode and execute. One bundle
// of NUM_OPNDS operand descriptors (kind, direct value, effective address) is
// accepted together with a snapshot of NUM_HINTS memory hints. Operands are
// then resolved one per cycle, and the complete set of resolved values is
// offered to execute over a valid/ready handshake.
//
// Operand kinds: 00 none -> 0, 01 direct -> in_direct, 10 mem -> data of the
// lowest-index read hint whose address matches exactly, 11 mem-phony -> the
// effective address itself, zero-extended.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready descriptor bundle handshake (ready only in IDLE)
//   in_kind           2 bits per operand
//   in_direct         DATA_W per operand
//   in_addr           ADDR_W per operand
//   hint_is_write     per-hint write flag (write hints never match)
//   hint_addr         ADDR_W per hint
//   hint_data         DATA_W per hint
//   kill              synchronous abort of the in-flight bundle
//   out_valid/out_ready resolved bundle handshake
//   out_opnd          DATA_W per operand, resolved values
//   out_miss          per operand: mem kind with no matching read hint
//   out_err           miss summary (only with the macro below)
//
// Build option:
//   OPND_RESOLVE_MISS_ERR_EN - when defined, a missed mem operand resolves to
//   all-ones and out_err is raised in DONE if any operand missed. When not
//   defined, a miss resolves to 0 and out_err is tied low.
// ---------------------------------------------------------------------------
module opnd_resolve_seq #(
    parameter int NUM_OPNDS = 3,
    parameter int NUM_HINTS = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2*NUM_OPNDS-1:0]      in_kind,
    input  logic [DATA_W*NUM_OPNDS-1:0] in_direct,
    input  logic [ADDR_W*NUM_OPNDS-1:0] in_addr,
    input  logic [NUM_HINTS-1:0]        hint_is_write,
    input  logic [ADDR_W*NUM_HINTS-1:0] hint_addr,
    input  logic [DATA_W*NUM_HINTS-1:0] hint_data,
    input  logic                        kill,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W*NUM_OPNDS-1:0] out_opnd,
    output logic [NUM_OPNDS-1:0]        out_miss,
    output logic                        out_err
);

    localparam int IDX_W = (NUM_OPNDS > 1) ? $clog2(NUM_OPNDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPNDS - 1);

    localparam logic [1:0] KIND_NONE   = 2'b00;
    localparam logic [1:0] KIND_DIRECT = 2'b01;
    localparam logic [1:0] KIND_MEM    = 2'b10;
    localparam logic [1:0] KIND_PHONY  = 2'b11;

`ifdef OPND_RESOLVE_MISS_ERR_EN
    localparam logic [DATA_W-1:0] MISS_VALUE = '1;
`else
    localparam logic [DATA_W-1:0] MISS_VALUE = '0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESOLVE,
        ST_DONE
    } state_t;

    state_t                      state_q;
    state_t                      state_d;
    logic [IDX_W-1:0]            idx_q;

    logic [2*NUM_OPNDS-1:0]      kind_q;
    logic [DATA_W*NUM_OPNDS-1:0] direct_q;
    logic [ADDR_W*NUM_OPNDS-1:0] addr_q;
    logic [NUM_HINTS-1:0]        hint_wr_q;
    logic [ADDR_W*NUM_HINTS-1:0] hint_addr_q;
    logic [DATA_W*NUM_HINTS-1:0] hint_data_q;

    logic                        accept;
    logic                        resolve_step;

    logic [1:0]                  cur_kind;
    logic [DATA_W-1:0]           cur_direct;
    logic [ADDR_W-1:0]           cur_addr;
    logic                        hit;
    logic [DATA_W-1:0]           hit_data;
    logic [DATA_W-1:0]           res_value;
    logic                        res_miss;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);

    // kill wins over a pending accept in IDLE.
    assign accept       = (state_q == ST_IDLE) && in_valid && !kill;
    assign resolve_step = (state_q == ST_RESOLVE) && !kill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                if (kill) begin
                    state_d = ST_IDLE;
                end else if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (kill || out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Resolve the operand currently selected by idx_q. The hint scan runs from
    // the highest index down so that the lowest matching hint overwrites last.
    always_comb begin
        cur_kind   = kind_q[2*int'(idx_q) +: 2];
        cur_direct = direct_q[int'(idx_q)*DATA_W +: DATA_W];
        cur_addr   = addr_q[int'(idx_q)*ADDR_W +: ADDR_W];
        hit        = 1'b0;
        hit_data   = '0;
        for (int h = NUM_HINTS - 1; h >= 0; h--) begin
            if (!hint_wr_q[h] && (hint_addr_q[h*ADDR_W +: ADDR_W] == cur_addr)) begin
                hit      = 1'b1;
                hit_data = hint_data_q[h*DATA_W +: DATA_W];
            end
        end
        res_value = '0;
        res_miss  = 1'b0;
        case (cur_kind)
            KIND_NONE: begin
                res_value = '0;
            end
            KIND_DIRECT: begin
                res_value = cur_direct;
            end
            KIND_MEM: begin
                res_value = hit ? hit_data : MISS_VALUE;
                res_miss  = !hit;
            end
            KIND_PHONY: begin
                res_value = DATA_W'(cur_addr);
            end
            default: begin
                res_value = '0;
            end
        endcase
    end

    // Bundle capture and per-slot result write-back. A killed step writes
    // nothing, so the outputs keep their last (now invalid) contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            kind_q      <= '0;
            direct_q    <= '0;
            addr_q      <= '0;
            hint_wr_q   <= '0;
            hint_addr_q <= '0;
            hint_data_q <= '0;
            out_opnd    <= '0;
            out_miss    <= '0;
        end else if (accept) begin
            idx_q       <= '0;
            kind_q      <= in_kind;
            direct_q    <= in_direct;
            addr_q      <= in_addr;
            hint_wr_q   <= hint_is_write;
            hint_addr_q <= hint_addr;
            hint_data_q <= hint_data;
            out_opnd    <= '0;
            out_miss    <= '0;
        end else if (resolve_step) begin
            out_opnd[int'(idx_q)*DATA_W +: DATA_W] <= res_value;
            out_miss[idx_q]                        <= res_miss;
            if (idx_q != LAST_IDX) begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

`ifdef OPND_RESOLVE_MISS_ERR_EN
    logic err_q;

    // The error flag is computed on the final resolve edge so it is already
    // valid in the first DONE cycle; slots not yet written are still zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept || kill) begin
            err_q <= 1'b0;
        end else if (resolve_step && (idx_q == LAST_IDX)) begin
            err_q <= (|out_miss) | res_miss;
        end
    end

    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_opnd_resolve_seq.sv
// ---------------------------------------------------------------------------
// tb_opnd_resolve_seq
//
// Scoreboard bench for opnd_resolve_seq. Each accepted bundle pushes the
// reference model's expected result into a queue; an independent monitor
// pops and compares whenever the DUT completes an output handshake.
// Directed scenarios cover latency, hint priority, write hints, mem-phony,
// misses, output stall, kill and asynchronous reset; a randomized phase
// follows.
// ---------------------------------------------------------------------------
module tb_opnd_resolve_seq;

    localparam int NO = 3;
    localparam int NH = 2;
    localparam int DW = 32;
    localparam int AW = 32;

`ifdef OPND_RESOLVE_MISS_ERR_EN
    localparam logic [DW-1:0] MISS_VAL = '1;
    localparam bit            ERR_EN   = 1'b1;
`else
    localparam logic [DW-1:0] MISS_VAL = '0;
    localparam bit            ERR_EN   = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [2*NO-1:0]   in_kind;
    logic [DW*NO-1:0]  in_direct;
    logic [AW*NO-1:0]  in_addr;
    logic [NH-1:0]     hint_is_write;
    logic [AW*NH-1:0]  hint_addr;
    logic [DW*NH-1:0]  hint_data;
    logic              kill;
    logic              out_valid;
    logic              out_ready;
    logic [DW*NO-1:0]  out_opnd;
    logic [NO-1:0]     out_miss;
    logic              out_err;

    typedef struct packed {
        logic [DW*NO-1:0] opnd;
        logic [NO-1:0]    miss;
        logic             err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [1:0]    s_kind[NO];
    logic [DW-1:0] s_direct[NO];
    logic [AW-1:0] s_addr[NO];
    logic          s_hw[NH];
    logic [AW-1:0] s_ha[NH];
    logic [DW-1:0] s_hd[NH];

    opnd_resolve_seq #(
        .NUM_OPNDS(NO),
        .NUM_HINTS(NH),
        .DATA_W   (DW),
        .ADDR_W   (AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_kind      (in_kind),
        .in_direct    (in_direct),
        .in_addr      (in_addr),
        .hint_is_write(hint_is_write),
        .hint_addr    (hint_addr),
        .hint_data    (hint_data),
        .kill         (kill),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_opnd     (out_opnd),
        .out_miss     (out_miss),
        .out_err      (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out, expected event did not occur", name);
    endtask

    // Reference model: operand-by-operand from the kind rules, using the
    // hint snapshot held in the stimulus arrays.
    function automatic exp_t model();
        exp_t e;
        e = '0;
        for (int i = 0; i < NO; i++) begin
            logic [DW-1:0] v;
            bit            found;
            v     = '0;
            found = 1'b0;
            case (s_kind[i])
                2'b01: v = s_direct[i];
                2'b11: v = DW'(s_addr[i]);
                2'b10: begin
                    for (int h = 0; h < NH; h++) begin
                        if (!found && !s_hw[h] && s_ha[h] == s_addr[i]) begin
                            v     = s_hd[h];
                            found = 1'b1;
                        end
                    end
                    if (!found) begin
                        v         = MISS_VAL;
                        e.miss[i] = 1'b1;
                    end
                end
                default: v = '0;
            endcase
            e.opnd[i*DW +: DW] = v;
        end
        e.err = ERR_EN && (e.miss != '0);
        return e;
    endfunction

    function automatic logic [AW-1:0] pickAddr();
        case ($urandom_range(0, 3))
            0: return 32'h0000_1000;
            1: return 32'h0000_2000;
            2: return 32'h0000_3000;
            default: return $urandom;
        endcase
    endfunction

    task automatic clearStim();
        for (int i = 0; i < NO; i++) begin
            s_kind[i]   = 2'b00;
            s_direct[i] = $urandom;
            s_addr[i]   = $urandom;
        end
        for (int h = 0; h < NH; h++) begin
            s_hw[h] = 1'b1;
            s_ha[h] = $urandom;
            s_hd[h] = $urandom;
        end
    endtask

    task automatic packStim();
        for (int i = 0; i < NO; i++) begin
            in_kind[2*i +: 2]    = s_kind[i];
            in_direct[i*DW +: DW] = s_direct[i];
            in_addr[i*AW +: AW]   = s_addr[i];
        end
        for (int h = 0; h < NH; h++) begin
            hint_is_write[h]      = s_hw[h];
            hint_addr[h*AW +: AW] = s_ha[h];
            hint_data[h*DW +: DW] = s_hd[h];
        end
    endtask

    // Called just after a rising edge. Offers the bundle until accepted,
    // records the expected result, then scrambles all inputs so only the
    // captured copy can produce the right answer.
    task automatic applyStimulus();
        int guard;
        guard = 0;
        packStim();
        in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            timeoutFail("accept");
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(model());
        @(posedge clk);
        #1;
        in_valid      = 1'b0;
        in_kind       = 6'($urandom);
        in_direct     = {$urandom, $urandom, $urandom};
        in_addr       = {$urandom, $urandom, $urandom};
        hint_is_write = 2'($urandom);
        hint_addr     = {$urandom, $urandom};
        hint_data     = {$urandom, $urandom};
    endtask

    task automatic waitValid(input string name);
        int guard;
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!out_valid) begin
            timeoutFail(name);
        end
    endtask

    // Scoreboard monitor: compares on each completed output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_unexpected: got out_valid=1, expected no pending bundle");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("sb_opnd", 128'(out_opnd), 128'(e.opnd));
                checkOutput("sb_miss", 128'(out_miss), 128'(e.miss));
                checkOutput("sb_err", 128'(out_err), 128'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        kill          = 1'b0;
        out_ready     = 1'b1;
        in_kind       = '0;
        in_direct     = '0;
        in_addr       = '0;
        hint_is_write = '0;
        hint_addr     = '0;
        hint_data     = '0;
        #3;
        checkOutput("rst_in_ready", 128'(in_ready), 128'(1'b1));
        checkOutput("rst_out_valid", 128'(out_valid), 128'(1'b0));
        checkOutput("rst_out_opnd", 128'(out_opnd), 128'(0));
        checkOutput("rst_out_miss", 128'(out_miss), 128'(0));
        checkOutput("rst_out_err", 128'(out_err), 128'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic bundle with exact latency check.
        clearStim();
        s_kind[0] = 2'b01; s_direct[0] = 32'h11;
        s_kind[1] = 2'b10; s_addr[1]   = 32'h1000;
        s_hw[0]   = 1'b0;  s_ha[0] = 32'h1000; s_hd[0] = 32'hCAFE_BABE;
        applyStimulus();
        for (int k = 1; k <= NO; k++) begin
            @(posedge clk);
            #1;
            checkOutput("latency_valid", 128'(out_valid), 128'(k == NO));
        end
        checkOutput("t1_opnd", 128'(out_opnd), {32'h0, 32'h0, 32'hCAFE_BABE, 32'h11});
        checkOutput("t1_miss", 128'(out_miss), 128'(0));
        checkOutput("t1_in_ready", 128'(in_ready), 128'(1'b0));
        @(posedge clk);
        #1;

        // Write hint is skipped; read hint at index 1 supplies the data.
        clearStim();
        s_kind[0] = 2'b10; s_addr[0] = 32'h2000;
        s_hw[0] = 1'b1; s_ha[0] = 32'h2000; s_hd[0] = 32'h9;
        s_hw[1] = 1'b0; s_ha[1] = 32'h2000; s_hd[1] = 32'h5;
        applyStimulus();
        waitValid("t2_valid");
        checkOutput("t2_write_skip", 128'(out_opnd[DW-1:0]), 128'(32'h5));
        @(posedge clk);
        #1;

        // Both hints match as reads; the lowest index wins.
        s_hw[0] = 1'b0; s_hd[0] = 32'h7;
        applyStimulus();
        waitValid("t3_valid");
        checkOutput("t3_lowest_wins", 128'(out_opnd[DW-1:0]), 128'(32'h7));
        @(posedge clk);
        #1;

        // mem-phony yields the address itself.
        clearStim();
        s_kind[2] = 2'b11; s_addr[2] = 32'h0040_0010;
        applyStimulus();
        waitValid("t4_valid");
        checkOutput("t4_phony", 128'(out_opnd[2*DW +: DW]), 128'(32'h0040_0010));
        checkOutput("t4_phony_miss", 128'(out_miss), 128'(0));
        @(posedge clk);
        #1;

        // Unmatched mem operand reports a miss.
        clearStim();
        s_kind[1] = 2'b10; s_addr[1] = 32'h3000;
        s_hw[0] = 1'b0; s_ha[0] = 32'h3001; s_hd[0] = 32'h1234;
        applyStimulus();
        waitValid("t5_valid");
        checkOutput("t5_miss_bit", 128'(out_miss), 128'(3'b010));
        checkOutput("t5_miss_val", 128'(out_opnd[DW +: DW]), 128'(MISS_VAL));
        checkOutput("t5_err", 128'(out_err), 128'(ERR_EN));
        @(posedge clk);
        #1;

        // Output stall: DONE must hold for five cycles, then release.
        begin
            logic [DW*NO-1:0] held;
            out_ready = 1'b0;
            clearStim();
            s_kind[0] = 2'b01; s_direct[0] = 32'hA1B2_C3D4;
            s_kind[2] = 2'b11; s_addr[2]   = 32'h0000_BEEF;
            applyStimulus();
            waitValid("stall_valid");
            held = out_opnd;
            for (int k = 0; k < 5; k++) begin
                @(posedge clk);
                #1;
                checkOutput("stall_valid_hold", 128'(out_valid), 128'(1'b1));
                checkOutput("stall_opnd_hold", 128'(out_opnd), 128'(held));
                checkOutput("stall_in_ready", 128'(in_ready), 128'(1'b0));
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            checkOutput("release_valid", 128'(out_valid), 128'(1'b0));
            checkOutput("release_in_ready", 128'(in_ready), 128'(1'b1));
        end
        clearStim();
        s_kind[1] = 2'b01; s_direct[1] = 32'h55;
        applyStimulus();
        checkOutput("back_accept", 128'(in_ready), 128'(1'b0));
        waitValid("back_valid");
        @(posedge clk);
        #1;

        // Kill at idx=1: back to IDLE next edge, no output ever.
        clearStim();
        s_kind[0] = 2'b01; s_direct[0] = 32'h77;
        applyStimulus();
        @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        void'(exp_q.pop_back());
        checkOutput("kill_idle", 128'(in_ready), 128'(1'b1));
        for (int k = 0; k < 4; k++) begin
            checkOutput("kill_no_valid", 128'(out_valid), 128'(1'b0));
            @(posedge clk);
            #1;
        end

        // Kill in IDLE blocks the accept.
        clearStim();
        packStim();
        in_valid = 1'b1;
        kill     = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        kill     = 1'b0;
        checkOutput("kill_idle_no_accept", 128'(in_ready), 128'(1'b1));

        // Asynchronous reset mid-RESOLVE.
        clearStim();
        s_kind[0] = 2'b01; s_direct[0] = 32'hA5A5_0001;
        applyStimulus();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        checkOutput("arst_in_ready", 128'(in_ready), 128'(1'b1));
        checkOutput("arst_out_valid", 128'(out_valid), 128'(1'b0));
        checkOutput("arst_out_opnd", 128'(out_opnd), 128'(0));
        checkOutput("arst_out_miss", 128'(out_miss), 128'(0));
        checkOutput("arst_out_err", 128'(out_err), 128'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized bundles drawn from a small address pool to force hits.
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < NO; i++) begin
                s_kind[i]   = 2'($urandom_range(0, 3));
                s_direct[i] = $urandom;
                s_addr[i]   = pickAddr();
            end
            for (int h = 0; h < NH; h++) begin
                s_hw[h] = 1'($urandom_range(0, 1));
                s_ha[h] = pickAddr();
                s_hd[h] = $urandom;
            end
            applyStimulus();
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        begin
            int guard;
            guard = 0;
            while (exp_q.size() != 0 && guard < 100) begin
                @(posedge clk);
                guard++;
            end
            #1;
            checkOutput("sb_drain", 128'(exp_q.size()), 128'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
